alu_arbiter: RTL and testbench

Two-requester front end for the shared single-cycle `alu`: arbitrates round-robin between the main datapath and a second client (e.g. a shift/multiply microsequencer), registers operands, sequences one ALU operation at a time, and returns the result over a valid/ready response channel. Owns the architectural PSR register, updating only the flags each opcode defines and holding all others.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu.sv | 66 ++++++
 rtl/alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, PSR bit positions, arbiter FSM states and the
// per-opcode PSR write mask shared by the alu and alu_arbiter.
package alu_pkg;

   localparam logic [3:0] ADD  = 4'b0000;
   localparam logic [3:0] SUB  = 4'b0001;
   localparam logic [3:0] AND  = 4'b0010;
   localparam logic [3:0] XOR  = 4'b0011;
   localparam logic [3:0] OR   = 4'b0100;
   localparam logic [3:0] CMP  = 4'b0101;
   localparam logic [3:0] MOV  = 4'b0110;
   localparam logic [3:0] LSH  = 4'b0111;
   localparam logic [3:0] LSHI = 4'b1000;
   localparam logic [3:0] LUI  = 4'b1001;
   localparam logic [3:0] RANI = 4'b1111;

   localparam int PSR_W = 5;
   localparam int PSR_C = 0;
   localparam int PSR_F = 1;
   localparam int PSR_L = 2;
   localparam int PSR_Z = 3;
   localparam int PSR_N = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } arb_state_e;

   // Architectural flags each opcode is allowed to write; all others hold.
   function automatic logic [PSR_W-1:0] psr_write_mask(input logic [3:0] op);
      logic [PSR_W-1:0] mask;
      mask = 5'b00000;
      case (op)
         ADD, SUB: begin
            mask[PSR_C] = 1'b1;
            mask[PSR_F] = 1'b1;
         end
         CMP: begin
            mask[PSR_L] = 1'b1;
            mask[PSR_Z] = 1'b1;
            mask[PSR_N] = 1'b1;
         end
         default: mask = 5'b00000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational ALU. Result is Rdest op Rsrc; flags are
// always computed and the caller chooses which ones become architectural.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int RAND_W = 4
) (
   input  logic [WIDTH-1:0]  src_i,
   input  logic [WIDTH-1:0]  dest_i,
   input  logic [3:0]        alucont_i,
   input  logic [RAND_W-1:0] random_num_i,
   output logic [WIDTH-1:0]  result_o,
   output logic [PSR_W-1:0]  psr_o
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic [WIDTH-1:0] neg_src_s;
   logic             add_ovf_s;
   logic             sub_ovf_s;

   assign sum_s     = {1'b0, dest_i} + {1'b0, src_i};
   assign diff_s    = {1'b0, dest_i} - {1'b0, src_i};
   assign neg_src_s = (~src_i) + {{(WIDTH-1){1'b0}}, 1'b1};
   assign add_ovf_s = (dest_i[WIDTH-1] == src_i[WIDTH-1]) && (sum_s[WIDTH-1] != dest_i[WIDTH-1]);
   assign sub_ovf_s = (dest_i[WIDTH-1] != src_i[WIDTH-1]) && (diff_s[WIDTH-1] != dest_i[WIDTH-1]);

   // Result select; LSH treats a negative Rsrc as a right-shift amount.
   always_comb begin
      result_o = {WIDTH{1'b0}};
      case (alucont_i)
         ADD:  result_o = sum_s[WIDTH-1:0];
         SUB:  result_o = diff_s[WIDTH-1:0];
         AND:  result_o = dest_i & src_i;
         XOR:  result_o = dest_i ^ src_i;
         OR:   result_o = dest_i | src_i;
         CMP:  result_o = {WIDTH{1'b0}};
         MOV:  result_o = src_i;
         LSH: begin
            if (src_i[WIDTH-1]) begin
               result_o = dest_i >> neg_src_s[SH_W-1:0];
            end else begin
               result_o = dest_i << src_i[SH_W-1:0];
            end
         end
         LSHI: result_o = dest_i << src_i[SH_W-1:0];
         LUI:  result_o = src_i << (WIDTH/2);
         RANI: result_o = {{(WIDTH-RAND_W){1'b0}}, random_num_i};
         default: result_o = {WIDTH{1'b0}};
      endcase
   end

   // Flag generation: carry is a borrow for SUB.
   always_comb begin
      psr_o        = 5'b00000;
      psr_o[PSR_C] = (alucont_i == SUB) ? diff_s[WIDTH] : sum_s[WIDTH];
      psr_o[PSR_F] = (alucont_i == SUB) ? sub_ovf_s : add_ovf_s;
      psr_o[PSR_L] = diff_s[WIDTH];
      psr_o[PSR_Z] = (dest_i == src_i);
      psr_o[PSR_N] = ($signed(dest_i) < $signed(src_i));
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for the shared alu with a
// valid/ready response channel and the architectural PSR. Define ALU_ARB_LOCK_EN
// to let a requester hold the grant across consecutive ops via req_lock_*.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int RAND_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_0,
   input  logic              req_valid_1,
   output logic              req_ready_0,
   output logic              req_ready_1,
   input  logic [3:0]        req_op_0,
   input  logic [3:0]        req_op_1,
   input  logic [WIDTH-1:0]  req_src_0,
   input  logic [WIDTH-1:0]  req_src_1,
   input  logic [WIDTH-1:0]  req_dest_0,
   input  logic [WIDTH-1:0]  req_dest_1,
   input  logic              req_lock_0,
   input  logic              req_lock_1,
   input  logic [RAND_W-1:0] random_num,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_result,
   output logic [PSR_W-1:0]  psr
);

   arb_state_e       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] src_q, src_d;
   logic [WIDTH-1:0] dest_q, dest_d;
   logic             id_q, id_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [PSR_W-1:0] psr_q, psr_d;

   logic             grant_s;
   logic             grant_ok_s;
   logic             accept_s;
   logic             lock_valid_s;
   logic             lock_id_s;
   logic [WIDTH-1:0] alu_result_s;
   logic [PSR_W-1:0] alu_psr_s;
   logic [PSR_W-1:0] psr_mask_s;

   // Grant selection: an active lock overrides round-robin.
   always_comb begin
      grant_s    = 1'b0;
      grant_ok_s = 1'b0;
      if (lock_valid_s) begin
         grant_s    = lock_id_s;
         grant_ok_s = lock_id_s ? req_valid_1 : req_valid_0;
      end else if (req_valid_0 && req_valid_1) begin
         grant_s    = ~last_grant_q;
         grant_ok_s = 1'b1;
      end else if (req_valid_0) begin
         grant_s    = 1'b0;
         grant_ok_s = 1'b1;
      end else if (req_valid_1) begin
         grant_s    = 1'b1;
         grant_ok_s = 1'b1;
      end else begin
         grant_s    = 1'b0;
         grant_ok_s = 1'b0;
      end
   end

   // Reset is folded in so no request is acked while it is asserted.
   assign accept_s    = reset && (state_q == ST_IDLE) && grant_ok_s;
   assign req_ready_0 = accept_s && !grant_s;
   assign req_ready_1 = accept_s && grant_s;

`ifdef ALU_ARB_LOCK_EN
   logic lock_valid_q, lock_valid_d;
   logic lock_id_q, lock_id_d;

   // Lock follows the lock bit of every accepted op.
   always_comb begin
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      if (accept_s) begin
         lock_valid_d = grant_s ? req_lock_1 : req_lock_0;
         lock_id_d    = grant_s;
      end else begin
         lock_valid_d = lock_valid_q;
         lock_id_d    = lock_id_q;
      end
   end

   // Lock state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_valid_q <= 1'b0;
         lock_id_q    <= 1'b0;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
      end
   end

   assign lock_valid_s = lock_valid_q;
   assign lock_id_s    = lock_id_q;
`else
   logic unused_lock_s;
   assign unused_lock_s = req_lock_0 ^ req_lock_1;
   assign lock_valid_s  = 1'b0;
   assign lock_id_s     = 1'b0;
`endif

   alu #(
      .WIDTH  (WIDTH),
      .RAND_W (RAND_W)
   ) u_alu (
      .src_i        (src_q),
      .dest_i       (dest_q),
      .alucont_i    (op_q),
      .random_num_i (random_num),
      .result_o     (alu_result_s),
      .psr_o        (alu_psr_s)
   );

   assign psr_mask_s = psr_write_mask(op_q);

   // Next-state and datapath capture for the IDLE -> EXEC -> DONE sequence.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      src_d        = src_q;
      dest_d       = dest_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      psr_d        = psr_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d         = grant_s ? req_op_1   : req_op_0;
               src_d        = grant_s ? req_src_1  : req_src_0;
               dest_d       = grant_s ? req_dest_1 : req_dest_0;
               id_d         = grant_s;
               last_grant_d = grant_s;
               state_d      = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_result_d = alu_result_s;
            rsp_id_d     = id_q;
            psr_d        = (psr_q & ~psr_mask_s) | (alu_psr_s & psr_mask_s);
            rsp_valid_d  = 1'b1;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         op_q         <= 4'b0000;
         src_q        <= {WIDTH{1'b0}};
         dest_q       <= {WIDTH{1'b0}};
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= {WIDTH{1'b0}};
         psr_q        <= 5'b00000;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         src_q        <= src_d;
         dest_q       <= dest_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         psr_q        <= psr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign psr        = psr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a
// transaction-level model (arbitration, results, PSR masking, timing, reset).
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid_0, req_valid_1;
   logic        req_ready_0, req_ready_1;
   logic [3:0]  req_op_0, req_op_1;
   logic [15:0] req_src_0, req_src_1, req_dest_0, req_dest_1;
   logic        req_lock_0, req_lock_1;
   logic [3:0]  random_num;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_result;
   logic [4:0]  psr;

   int checks = 0;
   int failures = 0;

   logic [4:0] psr_m;
   int         last_m;
   int         lock_m;

   alu_arbiter #(.WIDTH(16), .RAND_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .req_src_0(req_src_0), .req_src_1(req_src_1),
      .req_dest_0(req_dest_0), .req_dest_1(req_dest_1),
      .req_lock_0(req_lock_0), .req_lock_1(req_lock_1),
      .random_num(random_num),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .psr(psr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Behavioural ALU plus PSR masking on plain integers.
   task automatic model_exec(input int op, input int s, input int d, input int r, output logic [15:0] res);
      int t;
      t = 0;
      case (op)
         0: begin
            t = d + s;
            psr_m[0] = (t > 65535);
            psr_m[1] = ((sgn(d) + sgn(s)) > 32767) || ((sgn(d) + sgn(s)) < -32768);
         end
         1: begin
            t = d - s;
            psr_m[0] = (d < s);
            psr_m[1] = ((sgn(d) - sgn(s)) > 32767) || ((sgn(d) - sgn(s)) < -32768);
         end
         2: t = d & s;
         3: t = d ^ s;
         4: t = d | s;
         5: begin
            t = 0;
            psr_m[2] = (d < s);
            psr_m[3] = (d == s);
            psr_m[4] = (sgn(d) < sgn(s));
         end
         6: t = s;
         7: t = (s >= 32768) ? (d >> ((65536 - s) % 16)) : (d << (s % 16));
         8: t = d << (s % 16);
         9: t = (s % 256) * 256;
         15: t = r;
         default: t = 0;
      endcase
      res = 16'(t);
   endtask

   function automatic int exp_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_LOCK_EN
      if (lock_m >= 0) return ((lock_m == 0 && v0) || (lock_m == 1 && v1)) ? lock_m : -1;
`endif
      if (v0 && v1) return 1 - last_m;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // One complete transaction; entered and left just after a falling edge.
   task automatic run_txn(input logic v0, input logic v1, input logic [3:0] op0, input logic [3:0] op1,
                          input logic [15:0] s0, input logic [15:0] d0, input logic [15:0] s1,
                          input logic [15:0] d1, input logic l0, input logic l1, input int wait_cyc,
                          output int gid);
      int          eg;
      int          rnd;
      logic [15:0] exp_res;
      rnd = $urandom_range(0, 15);
      req_valid_0 = v0; req_op_0 = op0; req_src_0 = s0; req_dest_0 = d0; req_lock_0 = l0;
      req_valid_1 = v1; req_op_1 = op1; req_src_1 = s1; req_dest_1 = d1; req_lock_1 = l1;
      random_num  = 4'(rnd);
      rsp_ready   = 1'b0;
      eg  = exp_grant(v0, v1);
      gid = eg;
      #1;
      chk("ready0", {31'd0, req_ready_0}, {31'd0, eg == 0});
      chk("ready1", {31'd0, req_ready_1}, {31'd0, eg == 1});
      @(posedge clk);
      if (eg < 0) begin
         @(negedge clk);
         return;
      end
      last_m = eg;
`ifdef ALU_ARB_LOCK_EN
      lock_m = ((eg == 0) ? l0 : l1) ? eg : -1;
`endif
      if (eg == 0) model_exec(op0, s0, d0, rnd, exp_res);
      else         model_exec(op1, s1, d1, rnd, exp_res);
      @(negedge clk);
      chk("exec_valid", {31'd0, rsp_valid}, 32'd0);
      chk("exec_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
      @(negedge clk);
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_result", {16'd0, rsp_result}, {16'd0, exp_res});
      chk("rsp_id", {31'd0, rsp_id}, eg);
      chk("psr", {27'd0, psr}, {27'd0, psr_m});
      for (int i = 0; i < wait_cyc; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_result", {16'd0, rsp_result}, {16'd0, exp_res});
         chk("hold_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b0;
   endtask

   function automatic logic [15:0] pick_val();
      logic [15:0] corners [6];
      corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000;
      corners[3] = 16'h7FFF; corners[4] = 16'h0001; corners[5] = 16'h00FF;
      if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
      return 16'($urandom);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g;
      int seq [4];
      psr_m = 5'b00000; last_m = 1; lock_m = -1;
      reset = 1'b0; rsp_ready = 1'b0; random_num = 4'd0;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      req_op_0 = 4'd0; req_op_1 = 4'd0; req_src_0 = 16'd0; req_src_1 = 16'd0;
      req_dest_0 = 16'd0; req_dest_1 = 16'd0; req_lock_0 = 1'b0; req_lock_1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_psr", {27'd0, psr}, 32'd0);
      chk("rst_result", {16'd0, rsp_result}, 32'd0);
      chk("rst_id", {31'd0, rsp_id}, 32'd0);
      reset = 1'b1;

      run_txn(1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0001, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 0, g);
      chk("add_result", {16'd0, rsp_result}, 32'h0000);
      chk("add_psr", {27'd0, psr}, 32'h01);
      run_txn(1'b0, 1'b1, 4'b0000, 4'b0101, 16'h0, 16'h0, 16'h0005, 16'h0003, 1'b0, 1'b0, 0, g);
      chk("cmp_psr", {27'd0, psr}, 32'h15);
      run_txn(1'b0, 1'b1, 4'b0000, 4'b0110, 16'h0, 16'h0, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 0, g);
      chk("mov_result", {16'd0, rsp_result}, 32'h1234);
      chk("mov_psr", {27'd0, psr}, 32'h15);

      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), pick_val(), pick_val(),
                 pick_val(), pick_val(), 1'b0, 1'b0, (i == 1) ? 5 : 0, g);
         seq[i] = g;
      end
      chk("rr_0", seq[0], 32'd0);
      chk("rr_1", seq[1], 32'd1);
      chk("rr_2", seq[2], 32'd0);
      chk("rr_3", seq[3], 32'd1);

      run_txn(1'b1, 1'b1, 4'b0101, 4'b0110, 16'h0009, 16'h0002, 16'h1111, 16'h0, 1'b1, 1'b0, 0, g);
      chk("lock_a", g, 32'd0);
      run_txn(1'b1, 1'b1, 4'b0000, 4'b0110, 16'h0003, 16'h0004, 16'h2222, 16'h0, 1'b0, 1'b0, 0, g);
`ifdef ALU_ARB_LOCK_EN
      chk("lock_b", g, 32'd0);
`else
      chk("lock_b", g, 32'd1);
`endif
      run_txn(1'b1, 1'b1, 4'b0000, 4'b0110, 16'h0003, 16'h0004, 16'h3333, 16'h0, 1'b0, 1'b0, 0, g);
`ifdef ALU_ARB_LOCK_EN
      chk("lock_c", g, 32'd1);
`else
      chk("lock_c", g, 32'd0);
`endif

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 pick_val(), pick_val(), pick_val(), pick_val(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), g);
      end

      run_txn(1'b1, 1'b1, 4'b0101, 4'b0101, 16'h0005, 16'h0003, 16'h0005, 16'h0003, 1'b0, 1'b0, 0, g);
      chk("pre_rst_psr", {27'd0, psr}, {27'd0, psr_m});
      req_valid_1 = 1'b0; req_valid_0 = 1'b1; req_op_0 = 4'b0000;
      req_src_0 = 16'h0001; req_dest_0 = 16'h7FFF; req_lock_0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_psr", {27'd0, psr}, 32'd0);
      chk("midrst_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("inrst_valid", {31'd0, rsp_valid}, 32'd0);
      end
      reset = 1'b1;
      psr_m = 5'b00000; last_m = 1; lock_m = -1;
      run_txn(1'b1, 1'b1, 4'b0001, 4'b0010, 16'h0002, 16'h0001, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1, g);
      chk("post_rst_grant", g, 32'd0);
      chk("post_rst_psr", {27'd0, psr}, 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
